// File: rtl/audio_adc_rx.sv
// Slave-mode serial audio receiver: oversamples codec BCK/LRCK/ADCDAT in the CLK_18_4
// domain and deserializes left-justified MSB-first words into left/right sample pairs.
module audio_adc_rx #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK_18_4,
  input  logic                  RST,
  input  logic                  AUD_BCK,
  input  logic                  AUD_ADCLRCK,
  input  logic                  AUD_ADCDAT,
  output logic [DATA_WIDTH-1:0] left_sample,
  output logic [DATA_WIDTH-1:0] right_sample,
  output logic                  sample_valid,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  logic [SYNC_STAGES-1:0] bck_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   bck_d;
  logic                   lrck_d;
  logic [DATA_WIDTH-1:0]  shift;
  logic [DATA_WIDTH-1:0]  left_hold;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   left_ok;

  logic                   bck_s;
  logic                   lrck_s;
  logic                   dat_s;
  logic                   bck_rise;
  logic                   lr_edge;
  logic [DATA_WIDTH-1:0]  word_next;

  assign bck_s     = bck_sync[SYNC_STAGES-1];
  assign lrck_s    = lrck_sync[SYNC_STAGES-1];
  assign dat_s     = dat_sync[SYNC_STAGES-1];
  assign bck_rise  = bck_s & ~bck_d;
  assign lr_edge   = lrck_s ^ lrck_d;
  assign word_next = {shift[DATA_WIDTH-2:0], dat_s};

  always_ff @(posedge CLK_18_4) begin
    if (RST) begin
      bck_sync     <= '0;
      lrck_sync    <= '0;
      dat_sync     <= '0;
      bck_d        <= 1'b0;
      lrck_d       <= 1'b0;
      shift        <= '0;
      left_hold    <= '0;
      bit_cnt      <= '0;
      left_ok      <= 1'b0;
      left_sample  <= '0;
      right_sample <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      bck_sync     <= {bck_sync[SYNC_STAGES-2:0], AUD_BCK};
      lrck_sync    <= {lrck_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sync     <= {dat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
      bck_d        <= bck_s;
      lrck_d       <= lrck_s;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;

      if (lr_edge) begin
        // A half-frame that ended part-way through its word is dropped.
        if (bit_cnt != '0 && bit_cnt != CNT_FULL) begin
          frame_err <= 1'b1;
          if (!lrck_d)
            left_ok <= 1'b0;
        end
        // A rise coincident with the LR edge is the MSB of the new word.
        if (bck_rise) begin
          shift   <= word_next;
          bit_cnt <= CNT_W'(1);
        end else begin
          bit_cnt <= '0;
        end
      end else if (bck_rise && bit_cnt != CNT_FULL) begin
        shift   <= word_next;
        bit_cnt <= bit_cnt + CNT_W'(1);
        if (bit_cnt == CNT_LAST) begin
          if (!lrck_s) begin
            left_hold <= word_next;
            left_ok   <= 1'b1;
          end else if (left_ok) begin
            left_sample  <= left_hold;
            right_sample <= word_next;
            sample_valid <= 1'b1;
            left_ok      <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_adc_rx.sv
// Scoreboard bench for audio_adc_rx: drives BCK/LRCK/ADCDAT frames and checks
// each strobed left/right pair and the frame_err pulse count.
module tb_audio_adc_rx;

  logic        CLK_18_4 = 1'b0;
  logic        RST = 1'b1;
  logic        AUD_BCK = 1'b0;
  logic        AUD_ADCLRCK = 1'b1;
  logic        AUD_ADCDAT = 1'b0;
  logic [15:0] left_sample;
  logic [15:0] right_sample;
  logic        sample_valid;
  logic        frame_err;

  audio_adc_rx #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .CLK_18_4    (CLK_18_4),
    .RST         (RST),
    .AUD_BCK     (AUD_BCK),
    .AUD_ADCLRCK (AUD_ADCLRCK),
    .AUD_ADCDAT  (AUD_ADCDAT),
    .left_sample (left_sample),
    .right_sample(right_sample),
    .sample_valid(sample_valid),
    .frame_err   (frame_err)
  );

  always #5 CLK_18_4 = ~CLK_18_4;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  int          ferr_seen = 0;
  int          ferr_exp = 0;
  logic        model_ok = 1'b0;
  logic [15:0] model_left = '0;
  logic        prev_v = 1'b0;
  logic        prev_f = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge CLK_18_4) begin
    if (sample_valid) begin
      logic [31:0] e;
      chk("valid_width", {31'd0, prev_v}, 32'd0);
      chk("valid_expected", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("left_sample", {16'd0, left_sample}, {16'd0, e[31:16]});
        chk("right_sample", {16'd0, right_sample}, {16'd0, e[15:0]});
      end
    end
    if (frame_err) begin
      ferr_seen++;
      chk("ferr_width", {31'd0, prev_f}, 32'd0);
    end
    prev_v = sample_valid;
    prev_f = frame_err;
  end

  // One BCK period of 12 clocks: data and LRCK change with the falling edge.
  task automatic bck_cycle(input logic d, input logic lr);
    AUD_BCK     = 1'b0;
    AUD_ADCDAT  = d;
    AUD_ADCLRCK = lr;
    repeat (6) @(negedge CLK_18_4);
    AUD_BCK = 1'b1;
    repeat (6) @(negedge CLK_18_4);
  endtask

  task automatic send_half(input logic lr, input logic [15:0] word, input int nslots, input logic trail);
    if (nslots >= 16) begin
      if (!lr) begin
        model_left = word;
        model_ok   = 1'b1;
      end else if (model_ok) begin
        sb_q.push_back({model_left, word});
        model_ok = 1'b0;
      end
    end else if (nslots > 0) begin
      ferr_exp++;
      if (!lr) model_ok = 1'b0;
    end
    for (int i = 0; i < nslots; i++)
      bck_cycle((i < 16) ? word[15-i] : trail, lr);
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_half(1'b0, l, 16, 1'b0);
    send_half(1'b1, r, 16, 1'b0);
  endtask

  initial begin
    logic [15:0] w;
    @(negedge CLK_18_4);

    // Start mid-frame: first 6 right bits under reset, then 10 seen by the receiver.
    w = 16'hC3A5;
    bck_cycle(w[15], 1'b1);
    chk("rst_left", {16'd0, left_sample}, 32'd0);
    chk("rst_right", {16'd0, right_sample}, 32'd0);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_ferr", {31'd0, frame_err}, 32'd0);
    for (int i = 1; i < 6; i++) bck_cycle(w[15-i], 1'b1);
    RST = 1'b0;
    for (int i = 6; i < 16; i++) bck_cycle(w[15-i], 1'b1);
    ferr_exp++;
    model_ok = 1'b0;
    send_frame(16'h0F0F, 16'hF0F0);
    chk("ferr_startmid", ferr_seen, ferr_exp);
    chk("sb_startmid", sb_q.size(), 0);

    // Nominal stream.
    for (int f = 0; f < 3; f++) send_frame(16'h1234, 16'hABCD);
    chk("ferr_nominal", ferr_seen, ferr_exp);
    chk("sb_nominal", sb_q.size(), 0);

    // Truncated left after 9 bits; following right is discarded.
    send_half(1'b0, 16'h1234, 9, 1'b0);
    send_half(1'b1, 16'h5555, 16, 1'b0);
    send_frame(16'h2468, 16'h1357);
    chk("ferr_trunc", ferr_seen, ferr_exp);
    chk("sb_trunc", sb_q.size(), 0);

    // Oversized 20-slot half-frames with trailing ones.
    send_half(1'b0, 16'h8001, 20, 1'b1);
    send_half(1'b1, 16'h7FFE, 20, 1'b1);
    send_frame(16'h0001, 16'h8000);
    chk("ferr_oversize", ferr_seen, ferr_exp);
    chk("sb_oversize", sb_q.size(), 0);

    // Sine table words including a negative value.
    send_frame(16'd0, 16'd4276);
    send_frame(16'd8480, 16'hEF4B);
    send_frame(16'hEF4B, 16'd0);
    chk("sb_sine", sb_q.size(), 0);

    // Reset after 8 right bits, with a valid left pending.
    send_half(1'b0, 16'h4321, 16, 1'b0);
    model_ok = 1'b0;
    w = 16'h9999;
    for (int i = 0; i < 8; i++) bck_cycle(w[15-i], 1'b1);
    AUD_BCK = 1'b0;
    RST = 1'b1;
    @(negedge CLK_18_4);
    RST = 1'b0;
    chk("midrst_left", {16'd0, left_sample}, 32'd0);
    chk("midrst_right", {16'd0, right_sample}, 32'd0);
    chk("midrst_valid", {31'd0, sample_valid}, 32'd0);
    repeat (96) @(negedge CLK_18_4);
    send_frame(16'h5A5A, 16'hA5A5);

    repeat (20) @(negedge CLK_18_4);
    chk("sb_drain", sb_q.size(), 0);
    chk("ferr_total", ferr_seen, ferr_exp);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
